// File: rtl/pc_redirect_ctrl.sv
// Control-flow sequencer between the EX branch unit and fetch: boot redirect, taken-branch
// redirect handshake, IF/ID flush window and taken-redirect counter. Optional BRANCH_MISALIGN_TRAP_EN.
module pc_redirect_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2
`ifdef BRANCH_MISALIGN_TRAP_EN
  ,
  parameter logic [31:0] TRAP_VEC     = 32'h0000_0100
`endif
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ex_valid,
  input  logic        i_b_taken,
  input  logic [31:0] i_b_pc,
  input  logic        i_stall,
  input  logic        i_fetch_ready,
  output logic        o_redirect_valid,
  output logic [31:0] o_redirect_pc,
  output logic        o_flush_if_id,
  output logic        o_busy,
  output logic [31:0] o_taken_cnt
`ifdef BRANCH_MISALIGN_TRAP_EN
  ,
  output logic        o_misalign
`endif
);

  localparam int unsigned PC_W   = 32;
  localparam int unsigned CNT_W  = 32;
  localparam int unsigned FCNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    IDLE     = 2'd1,
    REDIRECT = 2'd2,
    FLUSH    = 2'd3
  } state_t;

  state_t            state, state_n;
  logic              valid_n;
  logic [PC_W-1:0]   pc_n;
  logic              flush_n;
  logic              busy_n;
  logic [CNT_W-1:0]  cnt_n;
  logic [FCNT_W-1:0] fcnt, fcnt_n;
  logic [PC_W-1:0]   target_c;
  logic              capture_c;

  // Redirect target chosen at capture time
`ifdef BRANCH_MISALIGN_TRAP_EN
  logic misaligned_c;
  logic misalign_n;
  assign misaligned_c = (i_b_pc[1:0] != 2'b00);
  assign target_c     = misaligned_c ? TRAP_VEC : i_b_pc;
`else
  logic unused_pc_bits;
  assign unused_pc_bits = ^i_b_pc[1:0];
  assign target_c       = {i_b_pc[PC_W-1:2], 2'b00};
`endif

  assign capture_c = i_ex_valid & i_b_taken & ~i_stall;

  // Next-state and next-output logic
  always_comb begin
    state_n = state;
    valid_n = o_redirect_valid;
    pc_n    = o_redirect_pc;
    flush_n = o_flush_if_id;
    cnt_n   = o_taken_cnt;
    fcnt_n  = fcnt;
`ifdef BRANCH_MISALIGN_TRAP_EN
    misalign_n = 1'b0;
`endif
    unique case (state)
      BOOT: begin
        pc_n    = RESET_PC;
        flush_n = 1'b0;
        valid_n = 1'b1;
        if (o_redirect_valid && i_fetch_ready) begin
          valid_n = 1'b0;
          state_n = IDLE;
        end
      end
      IDLE: begin
        valid_n = 1'b0;
        flush_n = 1'b0;
        if (capture_c) begin
          state_n = REDIRECT;
          valid_n = 1'b1;
          flush_n = 1'b1;
          pc_n    = target_c;
`ifdef BRANCH_MISALIGN_TRAP_EN
          misalign_n = misaligned_c;
`endif
        end
      end
      REDIRECT: begin
        valid_n = 1'b1;
        flush_n = 1'b1;
        if (i_fetch_ready) begin
          valid_n = 1'b0;
          state_n = FLUSH;
          fcnt_n  = FCNT_W'(FLUSH_CYCLES - 1);
          if (o_taken_cnt != {CNT_W{1'b1}}) begin
            cnt_n = o_taken_cnt + CNT_W'(1);
          end
        end
      end
      FLUSH: begin
        valid_n = 1'b0;
        flush_n = 1'b1;
        if (fcnt == '0) begin
          state_n = IDLE;
          flush_n = 1'b0;
        end else begin
          fcnt_n = fcnt - FCNT_W'(1);
        end
      end
      default: begin
        state_n = BOOT;
      end
    endcase
    busy_n = (state_n != IDLE);
  end

  // State and output registers; reset aborts any in-flight redirect or flush
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state            <= BOOT;
      o_redirect_valid <= 1'b0;
      o_redirect_pc    <= RESET_PC;
      o_flush_if_id    <= 1'b0;
      o_busy           <= 1'b1;
      o_taken_cnt      <= '0;
      fcnt             <= '0;
`ifdef BRANCH_MISALIGN_TRAP_EN
      o_misalign       <= 1'b0;
`endif
    end else begin
      state            <= state_n;
      o_redirect_valid <= valid_n;
      o_redirect_pc    <= pc_n;
      o_flush_if_id    <= flush_n;
      o_busy           <= busy_n;
      o_taken_cnt      <= cnt_n;
      fcnt             <= fcnt_n;
`ifdef BRANCH_MISALIGN_TRAP_EN
      o_misalign       <= misalign_n;
`endif
    end
  end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl: redirect targets go through an expected-PC queue
// popped at each redirect handshake; control outputs are checked at fixed points.
module tb_pc_redirect_ctrl;

  localparam logic [31:0] RPC = 32'h0000_1000;
  localparam logic [31:0] TVEC = 32'h0000_0100;

  logic        i_clk;
  logic        i_rst;
  logic        i_ex_valid;
  logic        i_b_taken;
  logic [31:0] i_b_pc;
  logic        i_stall;
  logic        i_fetch_ready;
  logic        o_redirect_valid;
  logic [31:0] o_redirect_pc;
  logic        o_flush_if_id;
  logic        o_busy;
  logic [31:0] o_taken_cnt;
`ifdef BRANCH_MISALIGN_TRAP_EN
  logic        o_misalign;
`endif

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  pc_redirect_ctrl #(
    .RESET_PC    (RPC),
    .FLUSH_CYCLES(2)
  ) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_ex_valid      (i_ex_valid),
    .i_b_taken       (i_b_taken),
    .i_b_pc          (i_b_pc),
    .i_stall         (i_stall),
    .i_fetch_ready   (i_fetch_ready),
    .o_redirect_valid(o_redirect_valid),
    .o_redirect_pc   (o_redirect_pc),
    .o_flush_if_id   (o_flush_if_id),
    .o_busy          (o_busy),
    .o_taken_cnt     (o_taken_cnt)
`ifdef BRANCH_MISALIGN_TRAP_EN
    ,
    .o_misalign      (o_misalign)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for a redirect request, then compares its PC against the queue head
  task automatic wait_redirect(input string tag, input int budget);
    int n = 0;
    logic [31:0] exp;
    while (o_redirect_valid !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    assert (o_redirect_valid === 1'b1) else begin
      failures++;
      $error("FAIL %s_timeout observed=%b expected=1", tag, o_redirect_valid);
    end
    if (o_redirect_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk({tag, "_sb_underflow"}, 32'd1, 32'd0);
      end else begin
        exp = exp_q.pop_front();
        chk(tag, o_redirect_pc, exp);
      end
    end
  endtask

  task automatic drive_taken(input logic [31:0] pc);
    i_ex_valid = 1'b1;
    i_b_taken  = 1'b1;
    i_b_pc     = pc;
  endtask

  task automatic clear_ex();
    i_ex_valid = 1'b0;
    i_b_taken  = 1'b0;
  endtask

  initial begin
    i_rst = 1'b1; i_ex_valid = 1'b0; i_b_taken = 1'b0; i_b_pc = '0;
    i_stall = 1'b0; i_fetch_ready = 1'b1;

    // Reset and boot redirect
    tick(); tick();
    chk("rst_valid", o_redirect_valid, 0);
    chk("rst_pc", o_redirect_pc, RPC);
    chk("rst_flush", o_flush_if_id, 0);
    chk("rst_busy", o_busy, 1);
    chk("rst_cnt", o_taken_cnt, 0);
    exp_q.push_back(RPC);
    i_rst = 1'b0;
    tick();
    wait_redirect("boot_pc", 4);
    chk("boot_flush", o_flush_if_id, 0);
    chk("boot_busy", o_busy, 1);
    tick();
    chk("boot_idle_valid", o_redirect_valid, 0);
    chk("boot_idle_busy", o_busy, 0);
    chk("boot_cnt", o_taken_cnt, 0);

    // Taken branch accepted immediately
    drive_taken(32'h40);
    exp_q.push_back(32'h40);
    tick();
    clear_ex();
    chk("t2_flush0", o_flush_if_id, 1);
    chk("t2_busy", o_busy, 1);
    wait_redirect("t2_pc", 1);
    tick();
    chk("t2_valid_drop", o_redirect_valid, 0);
    chk("t2_flush1", o_flush_if_id, 1);
    chk("t2_cnt", o_taken_cnt, 1);
    tick();
    chk("t2_flush2", o_flush_if_id, 1);
    tick();
    chk("t2_flush_end", o_flush_if_id, 0);
    chk("t2_idle", o_busy, 0);

    // Fetch back-pressure for three cycles
    i_fetch_ready = 1'b0;
    drive_taken(32'h80);
    exp_q.push_back(32'h80);
    tick();
    clear_ex();
    for (int i = 0; i < 3; i++) begin
      chk("t3_hold_valid", o_redirect_valid, 1);
      chk("t3_hold_pc", o_redirect_pc, 32'h80);
      chk("t3_hold_flush", o_flush_if_id, 1);
      chk("t3_hold_cnt", o_taken_cnt, 1);
      tick();
    end
    i_fetch_ready = 1'b1;
    wait_redirect("t3_pc", 1);
    tick();
    chk("t3_cnt", o_taken_cnt, 2);
    chk("t3_valid_drop", o_redirect_valid, 0);
    tick(); tick();
    chk("t3_flush_end", o_flush_if_id, 0);
    chk("t3_idle", o_busy, 0);

    // Stalled branch is not captured; branch during flush is ignored
    i_stall = 1'b1;
    drive_taken(32'hC0);
    tick();
    chk("t4_stall_valid", o_redirect_valid, 0);
    chk("t4_stall_busy", o_busy, 0);
    chk("t4_stall_pc", o_redirect_pc, 32'h80);
    i_stall = 1'b0;
    drive_taken(32'h100);
    exp_q.push_back(32'h100);
    tick();
    clear_ex();
    wait_redirect("t4_pc", 1);
    tick();
    drive_taken(32'h200);
    tick();
    chk("t4_flush_ign_valid", o_redirect_valid, 0);
    chk("t4_flush_ign_flush", o_flush_if_id, 1);
    tick();
    clear_ex();
    chk("t4_idle_busy", o_busy, 0);
    chk("t4_idle_flush", o_flush_if_id, 0);
    chk("t4_cnt", o_taken_cnt, 3);
    tick();
    chk("t4_no_late_capture", o_redirect_valid, 0);
    chk("t4_pc_kept", o_redirect_pc, 32'h100);

    // Reset in the middle of a pending redirect
    i_fetch_ready = 1'b0;
    drive_taken(32'h140);
    tick();
    clear_ex();
    chk("t5_pending", o_redirect_valid, 1);
    i_rst = 1'b1;
    tick();
    chk("t5_rst_valid", o_redirect_valid, 0);
    chk("t5_rst_flush", o_flush_if_id, 0);
    chk("t5_rst_pc", o_redirect_pc, RPC);
    chk("t5_rst_cnt", o_taken_cnt, 0);
    chk("t5_rst_busy", o_busy, 1);
    i_rst = 1'b0;
    exp_q.push_back(RPC);
    i_fetch_ready = 1'b1;
    tick();
    wait_redirect("t5_boot_pc", 4);
    tick();
    chk("t5_idle", o_busy, 0);

    // Misaligned target
    i_fetch_ready = 1'b0;
    drive_taken(32'h42);
`ifdef BRANCH_MISALIGN_TRAP_EN
    exp_q.push_back(TVEC);
`else
    exp_q.push_back(32'h40);
`endif
    tick();
    clear_ex();
`ifdef BRANCH_MISALIGN_TRAP_EN
    chk("t6_misalign_first", o_misalign, 1);
`endif
    tick();
`ifdef BRANCH_MISALIGN_TRAP_EN
    chk("t6_misalign_second", o_misalign, 0);
`endif
    chk("t6_hold_valid", o_redirect_valid, 1);
    i_fetch_ready = 1'b1;
    wait_redirect("t6_pc", 1);
    tick();
    chk("t6_cnt", o_taken_cnt, 1);
    tick(); tick();
    chk("t6_idle", o_busy, 0);
    chk("sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
